// File: rtl/comm_pkg.sv
// Shared command codes, byte counts and state encodings for the console-mux link.
package comm_pkg;

  typedef logic [1:0] comm_cmd_t;

  localparam comm_cmd_t COMM_INVALID           = 2'd0;
  localparam comm_cmd_t COMM_READ_ENABLE_MASK  = 2'd1;
  localparam comm_cmd_t COMM_READ_PIN_MAP      = 2'd2;
  localparam comm_cmd_t COMM_WRITE_ENABLE_MASK = 2'd3;

  localparam int unsigned IDX_W = 3;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_TX_LOAD    = 3'd1;
  localparam logic [2:0] ST_TX_WAIT_LO = 3'd2;
  localparam logic [2:0] ST_TX_WAIT_HI = 3'd3;
  localparam logic [2:0] ST_RX_WAIT    = 3'd4;
  localparam logic [2:0] ST_DONE       = 3'd5;

  // Payload bytes following the command byte.
  function automatic logic [IDX_W-1:0] payload_bytes(input comm_cmd_t cmd);
    payload_bytes = (cmd == COMM_WRITE_ENABLE_MASK) ? 3'd2 : 3'd0;
  endfunction

  // Response bytes expected back from the responder.
  function automatic logic [IDX_W-1:0] response_bytes(input comm_cmd_t cmd);
    case (cmd)
      COMM_READ_ENABLE_MASK: response_bytes = 3'd2;
      COMM_READ_PIN_MAP:     response_bytes = 3'd4;
      default:               response_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/comm_host_if.sv
// Request/response and uart byte-level signals between comm_host and its neighbours.
interface comm_host_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_cmd;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        rx_ready;
  logic [7:0]  rx_data;

  modport master (
    input  req_valid, req_cmd, req_wdata, tx_done, rx_ready, rx_data,
    output req_ready, rsp_valid, rsp_data, rsp_err, tx_data, tx_start
  );

  modport slave (
    output req_valid, req_cmd, req_wdata, tx_done, rx_ready, rx_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err, tx_data, tx_start
  );
endinterface

// File: rtl/comm_timeout.sv
// Clearable, enabled cycle counter that flags when it reaches TIMEOUT_CYCLES.
module comm_timeout #(
  parameter  int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  logic [TO_W-1:0] cnt;

  assign tc_c = (cnt == TO_W'(TIMEOUT_CYCLES));

  // Count enabled cycles, holding at terminal count until cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc_c) begin
      cnt <= cnt + TO_W'(1);
    end
  end

endmodule

// File: rtl/comm_host.sv
// Host-side initiator: sends a command (plus write payload) and gathers read responses.
module comm_host #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input logic         clk,
  input logic         rst,
  comm_host_if.master bus
);
  import comm_pkg::*;

  logic [2:0]       state, state_nxt;
  comm_cmd_t        cmd_q, cmd_nxt;
  logic [15:0]      wdata_q, wdata_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             rx_prev;
  logic             rx_edge_c;
  logic             req_ready, rsp_valid, rsp_err, tx_start;
  logic [31:0]      rsp_data, rsp_data_nxt;
  logic             rsp_err_nxt, tx_start_nxt;
  logic [7:0]       tx_data, tx_data_nxt, tx_byte_c;
  logic             to_clr_c, to_en_c, to_tc_c;

  assign rx_edge_c     = bus.rx_ready & ~rx_prev;
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_err   = rsp_err;
  assign bus.tx_data   = tx_data;
  assign bus.tx_start  = tx_start;

  comm_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk  (clk),
    .rst  (rst),
    .clr  (to_clr_c),
    .en   (to_en_c),
    .tc_c (to_tc_c)
  );

  // Byte to launch next: command first, then payload LSB first.
  always_comb begin
    case (idx)
      3'd0:    tx_byte_c = {6'b0, cmd_q};
      3'd1:    tx_byte_c = wdata_q[7:0];
      default: tx_byte_c = wdata_q[15:8];
    endcase
  end

  // Next-state and next-output logic; progress always wins over timeout.
  always_comb begin
    state_nxt    = state;
    cmd_nxt      = cmd_q;
    wdata_nxt    = wdata_q;
    idx_nxt      = idx;
    rsp_data_nxt = rsp_data;
    rsp_err_nxt  = 1'b0;
    tx_data_nxt  = tx_data;
    tx_start_nxt = 1'b0;
    to_en_c      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid && req_ready) begin
          cmd_nxt      = bus.req_cmd;
          wdata_nxt    = bus.req_wdata;
          idx_nxt      = '0;
          rsp_data_nxt = '0;
          if (bus.req_cmd == COMM_INVALID) begin
            state_nxt   = ST_DONE;
            rsp_err_nxt = 1'b1;
          end else begin
            state_nxt = ST_TX_LOAD;
          end
        end
      end
      ST_TX_LOAD: begin
        to_en_c = 1'b1;
        if (bus.tx_done) begin
          tx_data_nxt  = tx_byte_c;
          tx_start_nxt = 1'b1;
          state_nxt    = ST_TX_WAIT_LO;
        end else if (to_tc_c) begin
          state_nxt   = ST_DONE;
          rsp_err_nxt = 1'b1;
        end
      end
      ST_TX_WAIT_LO: begin
        to_en_c = 1'b1;
        if (!bus.tx_done) begin
          state_nxt = ST_TX_WAIT_HI;
        end else if (to_tc_c) begin
          state_nxt   = ST_DONE;
          rsp_err_nxt = 1'b1;
        end
      end
      ST_TX_WAIT_HI: begin
        to_en_c = 1'b1;
        if (bus.tx_done) begin
          if (idx < payload_bytes(cmd_q)) begin
            idx_nxt   = idx + 3'd1;
            state_nxt = ST_TX_LOAD;
          end else if (response_bytes(cmd_q) != 3'd0) begin
            idx_nxt   = '0;
            state_nxt = ST_RX_WAIT;
          end else begin
            state_nxt = ST_DONE;
          end
        end else if (to_tc_c) begin
          state_nxt   = ST_DONE;
          rsp_err_nxt = 1'b1;
        end
      end
      ST_RX_WAIT: begin
        to_en_c = 1'b1;
        if (rx_edge_c) begin
          rsp_data_nxt[{idx[1:0], 3'b000} +: 8] = bus.rx_data;
          idx_nxt = idx + 3'd1;
          if ((idx + 3'd1) == response_bytes(cmd_q)) begin
            state_nxt = ST_DONE;
          end
        end else if (to_tc_c) begin
          state_nxt    = ST_DONE;
          rsp_err_nxt  = 1'b1;
          rsp_data_nxt = '0;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    to_clr_c = (state_nxt != state) || rx_edge_c;
  end

  // State, captured request and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_q     <= COMM_INVALID;
      wdata_q   <= '0;
      idx       <= '0;
      rx_prev   <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      tx_data   <= 8'hFF;
      tx_start  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_q     <= cmd_nxt;
      wdata_q   <= wdata_nxt;
      idx       <= idx_nxt;
      rx_prev   <= bus.rx_ready;
      req_ready <= (state_nxt == ST_IDLE);
      rsp_valid <= (state_nxt == ST_DONE);
      rsp_err   <= rsp_err_nxt;
      rsp_data  <= rsp_data_nxt;
      tx_data   <= tx_data_nxt;
      tx_start  <= tx_start_nxt;
    end
  end

endmodule

// File: tb/tb_comm_host.sv
// Directed bench for comm_host with a simple uart_tx model and a rsp_valid monitor.
module tb_comm_host;

  logic clk;
  logic rst;
  int   nvec, nerr, cyc;
  int   rsp_cnt, last_cyc, bad_start, tx_busy;
  logic [31:0] last_data;
  logic        last_err;
  logic [7:0]  tx_log[$];

  comm_host_if bus();

  comm_host #(.TIMEOUT_CYCLES(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter, advanced on the active edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Record every rsp_valid pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        rsp_cnt   = rsp_cnt + 1;
        last_data = bus.rsp_data;
        last_err  = bus.rsp_err;
        last_cyc  = cyc;
      end
    end
  end

  // uart_tx model: logs each started byte, busy (tx_done low) for three cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
        if (bus.tx_done !== 1'b1) bad_start = bad_start + 1;
        tx_log.push_back(bus.tx_data);
        bus.tx_done = 1'b0;
        tx_busy     = 3;
      end else if (tx_busy > 0) begin
        tx_busy = tx_busy - 1;
        if (tx_busy == 0) bus.tx_done = 1'b1;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Present a request for exactly one cycle, then scramble the inputs.
  task automatic issue(input logic [1:0] cmd, input logic [15:0] wd, output int acc_cyc);
    bus.req_valid = 1'b1;
    bus.req_cmd   = cmd;
    bus.req_wdata = wd;
    acc_cyc       = cyc;
    step();
    bus.req_valid = 1'b0;
    bus.req_cmd   = ~cmd;
    bus.req_wdata = ~wd;
  endtask

  task automatic send_rx(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    step();
    bus.rx_ready = 1'b0;
    bus.rx_data  = 8'h00;
    step();
  endtask

  task automatic wait_tx(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      step();
      ok = (tx_log.size() >= n) && (bus.tx_done === 1'b1);
    end
  endtask

  task automatic wait_rsp(input int base, input int limit, output bit got);
    got = (rsp_cnt != base);
    for (int i = 0; i < limit && !got; i++) begin
      step();
      got = (rsp_cnt != base);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    nvec++; if (bus.req_ready !== 1'b1) begin nerr++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
    nvec++; if (bus.rsp_valid !== 1'b0) begin nerr++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    nvec++; if (bus.rsp_err !== 1'b0) begin nerr++; $display("FAIL reset_rsp_err: got %b expected 0", bus.rsp_err); end
    nvec++; if (bus.rsp_data !== 32'h0) begin nerr++; $display("FAIL reset_rsp_data: got %h expected 00000000", bus.rsp_data); end
    nvec++; if (bus.tx_start !== 1'b0) begin nerr++; $display("FAIL reset_tx_start: got %b expected 0", bus.tx_start); end
    nvec++; if (bus.tx_data !== 8'hFF) begin nerr++; $display("FAIL reset_tx_data: got %h expected ff", bus.tx_data); end
    rst = 1'b0;
    step();
    step();
    nvec++; if (bus.req_ready !== 1'b1) begin nerr++; $display("FAIL idle_req_ready: got %b expected 1", bus.req_ready); end
  endtask

  task automatic test_read_enable_mask();
    int base, acc;
    bit ok, got;
    base = rsp_cnt;
    tx_log.delete();
    issue(2'd1, 16'hBEEF, acc);
    nvec++; if (bus.req_ready !== 1'b0) begin nerr++; $display("FAIL rem_busy_ready: got %b expected 0", bus.req_ready); end
    wait_tx(1, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL rem_tx_wait: got timeout expected byte sent"); end
    step();
    send_rx(8'h55);
    send_rx(8'hAA);
    wait_rsp(base, 20, got);
    nvec++; if (!got) begin nerr++; $display("FAIL rem_rsp: got no rsp_valid expected one"); end
    nvec++; if (last_data !== 32'h0000AA55) begin nerr++; $display("FAIL rem_data: got %h expected 0000aa55", last_data); end
    nvec++; if (last_err !== 1'b0) begin nerr++; $display("FAIL rem_err: got %b expected 0", last_err); end
    nvec++; if (tx_log.size() != 1 || tx_log[0] !== 8'h01) begin nerr++; $display("FAIL rem_tx: got %0d bytes first %h expected 1 byte 01", tx_log.size(), (tx_log.size() > 0) ? tx_log[0] : 8'hxx); end
    step();
    nvec++; if (bus.req_ready !== 1'b1) begin nerr++; $display("FAIL rem_ready_after: got %b expected 1", bus.req_ready); end
    step();
    nvec++; if (rsp_cnt != base + 1) begin nerr++; $display("FAIL rem_pulse_count: got %0d expected 1", rsp_cnt - base); end
  endtask

  task automatic test_read_pin_map();
    int base, acc;
    bit ok, got, rdy_hi;
    logic [7:0] rsp_bytes [4];
    rsp_bytes[0] = 8'hDD; rsp_bytes[1] = 8'hCC; rsp_bytes[2] = 8'hBB; rsp_bytes[3] = 8'hAA;
    base = rsp_cnt;
    tx_log.delete();
    issue(2'd2, 16'h0000, acc);
    rdy_hi = (bus.req_ready === 1'b1);
    wait_tx(1, ok);
    rdy_hi = rdy_hi | (bus.req_ready === 1'b1);
    nvec++; if (!ok) begin nerr++; $display("FAIL rpm_tx_wait: got timeout expected byte sent"); end
    step();
    for (int i = 0; i < 4; i++) begin
      rdy_hi = rdy_hi | (bus.req_ready === 1'b1);
      send_rx(rsp_bytes[i]);
    end
    wait_rsp(base, 20, got);
    nvec++; if (!got) begin nerr++; $display("FAIL rpm_rsp: got no rsp_valid expected one"); end
    nvec++; if (last_data !== 32'hAABBCCDD) begin nerr++; $display("FAIL rpm_data: got %h expected aabbccdd", last_data); end
    nvec++; if (last_err !== 1'b0) begin nerr++; $display("FAIL rpm_err: got %b expected 0", last_err); end
    nvec++; if (tx_log.size() != 1 || tx_log[0] !== 8'h02) begin nerr++; $display("FAIL rpm_tx: got %0d bytes expected 1 byte 02", tx_log.size()); end
    nvec++; if (rdy_hi) begin nerr++; $display("FAIL rpm_ready_low: got req_ready high while busy expected low"); end
    step();
  endtask

  task automatic test_write_enable_mask();
    int base, acc;
    bit got;
    base = rsp_cnt;
    tx_log.delete();
    bad_start = 0;
    issue(2'd3, 16'h1234, acc);
    wait_rsp(base, 100, got);
    nvec++; if (!got) begin nerr++; $display("FAIL wem_rsp: got no rsp_valid expected one"); end
    nvec++; if (tx_log.size() != 3) begin nerr++; $display("FAIL wem_tx_count: got %0d expected 3", tx_log.size()); end
    if (tx_log.size() == 3) begin
      nvec++; if (tx_log[0] !== 8'h03) begin nerr++; $display("FAIL wem_tx0: got %h expected 03", tx_log[0]); end
      nvec++; if (tx_log[1] !== 8'h34) begin nerr++; $display("FAIL wem_tx1: got %h expected 34", tx_log[1]); end
      nvec++; if (tx_log[2] !== 8'h12) begin nerr++; $display("FAIL wem_tx2: got %h expected 12", tx_log[2]); end
    end
    nvec++; if (bus.tx_done !== 1'b1) begin nerr++; $display("FAIL wem_rsp_after_done: got tx_done %b expected 1", bus.tx_done); end
    nvec++; if (last_data !== 32'h0) begin nerr++; $display("FAIL wem_data: got %h expected 00000000", last_data); end
    nvec++; if (last_err !== 1'b0) begin nerr++; $display("FAIL wem_err: got %b expected 0", last_err); end
    nvec++; if (bad_start != 0) begin nerr++; $display("FAIL wem_start_while_busy: got %0d expected 0", bad_start); end
    step();
  endtask

  task automatic test_invalid();
    int base, acc, ntx;
    bit got;
    base = rsp_cnt;
    ntx  = tx_log.size();
    issue(2'd0, 16'hFFFF, acc);
    wait_rsp(base, 5, got);
    nvec++; if (!got) begin nerr++; $display("FAIL inv_rsp: got no rsp_valid expected one"); end
    nvec++; if (last_cyc - acc != 1) begin nerr++; $display("FAIL inv_latency: got %0d expected 1", last_cyc - acc); end
    nvec++; if (last_err !== 1'b1) begin nerr++; $display("FAIL inv_err: got %b expected 1", last_err); end
    nvec++; if (last_data !== 32'h0) begin nerr++; $display("FAIL inv_data: got %h expected 00000000", last_data); end
    for (int i = 0; i < 8; i++) step();
    nvec++; if (tx_log.size() != ntx) begin nerr++; $display("FAIL inv_no_tx: got %0d bytes expected 0", tx_log.size() - ntx); end
  endtask

  task automatic test_timeout_back_to_back();
    int base, acc, t0, d;
    bit ok, got;
    base = rsp_cnt;
    tx_log.delete();
    issue(2'd2, 16'h0000, acc);
    wait_tx(1, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL to_tx_wait: got timeout expected byte sent"); end
    step();
    send_rx(8'h11);
    t0 = cyc;
    send_rx(8'h22);
    wait_rsp(base, 200, got);
    d = last_cyc - t0;
    nvec++; if (!got) begin nerr++; $display("FAIL to_rsp: got no rsp_valid expected one"); end
    nvec++; if (d < 64 || d > 68) begin nerr++; $display("FAIL to_delay: got %0d cycles expected 64..68", d); end
    nvec++; if (last_err !== 1'b1) begin nerr++; $display("FAIL to_err: got %b expected 1", last_err); end
    nvec++; if (last_data !== 32'h0) begin nerr++; $display("FAIL to_data: got %h expected 00000000", last_data); end
    step();
    nvec++; if (bus.req_ready !== 1'b1) begin nerr++; $display("FAIL b2b_ready: got %b expected 1", bus.req_ready); end
    base = rsp_cnt;
    tx_log.delete();
    issue(2'd1, 16'h0000, acc);
    wait_tx(1, ok);
    step();
    send_rx(8'h5A);
    send_rx(8'hC3);
    wait_rsp(base, 20, got);
    nvec++; if (!got || last_data !== 32'h0000C35A || last_err !== 1'b0) begin nerr++; $display("FAIL b2b_read: got valid %b data %h err %b expected 1 0000c35a 0", got, last_data, last_err); end
    step();
  endtask

  task automatic test_reset_mid();
    int base, acc, ntx;
    bit ok, got;
    base = rsp_cnt;
    tx_log.delete();
    issue(2'd1, 16'h0000, acc);
    wait_tx(1, ok);
    step();
    send_rx(8'h77);
    rst = 1'b1;
    step();
    nvec++; if (bus.rsp_data !== 32'h0) begin nerr++; $display("FAIL rmid_data: got %h expected 00000000", bus.rsp_data); end
    nvec++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin nerr++; $display("FAIL rmid_ctrl: got ready %b valid %b err %b expected 1 0 0", bus.req_ready, bus.rsp_valid, bus.rsp_err); end
    nvec++; if (bus.tx_data !== 8'hFF || bus.tx_start !== 1'b0) begin nerr++; $display("FAIL rmid_tx: got data %h start %b expected ff 0", bus.tx_data, bus.tx_start); end
    rst = 1'b0;
    step();
    send_rx(8'hAA);
    send_rx(8'h99);
    for (int i = 0; i < 6; i++) step();
    nvec++; if (rsp_cnt != base) begin nerr++; $display("FAIL rmid_no_rsp: got %0d pulses expected 0", rsp_cnt - base); end
    ntx = tx_log.size();
    nvec++; if (ntx != 1) begin nerr++; $display("FAIL rmid_stray_tx: got %0d bytes expected 1", ntx); end
    tx_log.delete();
    issue(2'd1, 16'h0000, acc);
    wait_tx(1, ok);
    step();
    send_rx(8'h0F);
    send_rx(8'hF0);
    wait_rsp(base, 20, got);
    nvec++; if (!got || last_data !== 32'h0000F00F || last_err !== 1'b0) begin nerr++; $display("FAIL rmid_fresh: got valid %b data %h err %b expected 1 0000f00f 0", got, last_data, last_err); end
    nvec++; if (tx_log.size() != 1 || tx_log[0] !== 8'h01) begin nerr++; $display("FAIL rmid_fresh_tx: got %0d bytes expected 1 byte 01", tx_log.size()); end
  endtask

  initial begin
    nvec = 0; nerr = 0; cyc = 0;
    rsp_cnt = 0; last_cyc = 0; bad_start = 0; tx_busy = 0;
    last_data = '0; last_err = 1'b0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_cmd   = 2'd0;
    bus.req_wdata = 16'h0;
    bus.tx_done   = 1'b1;
    bus.rx_ready  = 1'b0;
    bus.rx_data   = 8'h00;
    test_reset();
    test_read_enable_mask();
    test_read_pin_map();
    test_write_enable_mask();
    test_invalid();
    test_timeout_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
